// File: rtl/sb_pkg.sv
// Shared definitions for the SB multi-master transaction engine.
package sb_pkg;

    localparam int SB_DW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        RESP   = 2'd2
    } sb_state_e;

    typedef enum logic [1:0] {
        SB_OK          = 2'b00,
        SB_TIMEOUT     = 2'b01,
        SB_DECODE_MISS = 2'b10
    } sb_err_e;

endpackage

// File: rtl/sb_multi_master_irq.sv
// Single-channel interrupt latch: registered rising-edge detect feeding a
// set-dominant pending bit. The edge is registered before it sets the
// pending bit, so pend follows the irq rising edge by two cycles.
module sb_irq_latch (
    input  logic sb_clk_i,
    input  logic rst_n_i,
    input  logic irq_i,
    input  logic irq_clr_i,
    output logic pend_o
);

    logic prev_q, prev_d;
    logic edge_q, edge_d;
    logic pend_q, pend_d;

    // Edge detect and pending update; a new edge beats a simultaneous clear
    always_comb begin
        prev_d = irq_i;
        edge_d = irq_i & ~prev_q;
        pend_d = pend_q;
        if (edge_q) begin
            pend_d = 1'b1;
        end else if (irq_clr_i) begin
            pend_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge sb_clk_i) begin
        if (!rst_n_i) begin
            prev_q <= 1'b0;
            edge_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            edge_q <= edge_d;
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/sb_multi_master.sv
// SB transaction engine for up to four iCE40 hard-IP channels.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a request; decode channel from adr[7:4] on accept
// STROBE | sb_stb_o high, waiting for the selected channel's ack
// RESP   | rsp_valid_o high, holding response until rsp_ready_i
//
// Every output is registered. The strobe is low in both RESP and IDLE, so
// consecutive strobes are separated by at least two low cycles.
module sb_multi_master
    import sb_pkg::*;
#(
    parameter int          NUM_CH      = 2,
    parameter logic [15:0] CH_BASE     = 16'h0031,
    parameter int          TIMEOUT_CYC = 64
) (
    input  logic                    sb_clk_i,
    input  logic                    rst_n_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_wr_i,
    input  logic [7:0]              req_adr_i,
    input  logic [SB_DW-1:0]        req_dat_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [SB_DW-1:0]        rsp_dat_o,
    output logic [1:0]              rsp_err_o,
    output logic                    sb_stb_o,
    output logic                    sb_wr_o,
    output logic [7:0]              sb_adr_o,
    output logic [SB_DW-1:0]        sb_dat_o,
    input  logic [NUM_CH-1:0]       sb_ack_i,
    input  logic [SB_DW*NUM_CH-1:0] sb_dat_i,
    input  logic [NUM_CH-1:0]       irq_i,
    input  logic [NUM_CH-1:0]       irq_en_i,
    input  logic [NUM_CH-1:0]       irq_clr_i,
    output logic [NUM_CH-1:0]       irq_pend_o,
    output logic                    irq_o
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    sb_state_e        state_q, state_d;
    logic             ready_q, ready_d;
    logic [1:0]       sel_q, sel_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             stb_q, stb_d;
    logic             wr_q, wr_d;
    logic [7:0]       adr_q, adr_d;
    logic [SB_DW-1:0] dat_q, dat_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [SB_DW-1:0] rsp_dat_q, rsp_dat_d;
    logic [1:0]       rsp_err_q, rsp_err_d;

    logic             dec_hit;
    logic [1:0]       dec_ch;
    logic             ack_sel;
    logic [SB_DW-1:0] rdat_sel;

    // Address decode: lowest channel whose base nibble matches adr[7:4]
    always_comb begin
        dec_hit = 1'b0;
        dec_ch  = 2'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (CH_BASE[4*i +: 4] == req_adr_i[7:4]) begin
                dec_hit = 1'b1;
                dec_ch  = 2'(i);
            end
        end
    end

    // Only the selected channel's ack and read data are visible to the FSM
    always_comb begin
        ack_sel  = 1'b0;
        rdat_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_q == 2'(i)) begin
                ack_sel  = sb_ack_i[i];
                rdat_sel = sb_dat_i[SB_DW*i +: SB_DW];
            end
        end
    end

    // Transaction FSM next-state and registered-output values
    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        stb_d       = stb_q;
        wr_d        = wr_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (req_valid_i && ready_q) begin
                    ready_d = 1'b0;
                    if (dec_hit) begin
                        state_d = STROBE;
                        sel_d   = dec_ch;
                        cnt_d   = 8'd0;
                        stb_d   = 1'b1;
                        wr_d    = req_wr_i;
                        adr_d   = req_adr_i;
                        dat_d   = req_dat_i;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_dat_d   = '0;
                        rsp_err_d   = SB_DECODE_MISS;
                    end
                end
            end
            STROBE: begin
                cnt_d = cnt_q + 8'd1;
                // An ack in the expiry cycle still completes normally
                if (ack_sel || (cnt_q == CNT_LAST)) begin
                    state_d     = RESP;
                    stb_d       = 1'b0;
                    wr_d        = 1'b0;
                    adr_d       = '0;
                    dat_d       = '0;
                    rsp_valid_d = 1'b1;
                    if (ack_sel) begin
                        rsp_dat_d = wr_q ? '0 : rdat_sel;
                        rsp_err_d = SB_OK;
                    end else begin
                        rsp_dat_d = '0;
                        rsp_err_d = SB_TIMEOUT;
                    end
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    ready_d     = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_dat_d   = '0;
                    rsp_err_d   = SB_OK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM registers; reset discards any transaction in flight
    always_ff @(posedge sb_clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            sel_q       <= 2'd0;
            cnt_q       <= 8'd0;
            stb_q       <= 1'b0;
            wr_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= SB_OK;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            stb_q       <= stb_d;
            wr_q        <= wr_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_irq
            sb_irq_latch u_irq (
                .sb_clk_i  (sb_clk_i),
                .rst_n_i   (rst_n_i),
                .irq_i     (irq_i[g]),
                .irq_clr_i (irq_clr_i[g]),
                .pend_o    (irq_pend_o[g])
            );
        end
    endgenerate

    assign irq_o       = |(irq_pend_o & irq_en_i);
    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign sb_stb_o    = stb_q;
    assign sb_wr_o     = wr_q;
    assign sb_adr_o    = adr_q;
    assign sb_dat_o    = dat_q;

endmodule

// File: tb/tb_sb_multi_master.sv
// Bench for sb_multi_master: directed scenarios plus randomized traffic,
// checked against a transaction-level model of latency, strobe length,
// status and data, and a cycle-history model of the interrupt latches.
module tb_sb_multi_master;
    import sb_pkg::*;

    localparam int          NUM_CH  = 2;
    localparam logic [15:0] CH_BASE = 16'h0031;
    localparam int          TMO     = 64;

    logic                    sb_clk_i;
    logic                    rst_n_i;
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic                    req_wr_i;
    logic [7:0]              req_adr_i;
    logic [7:0]              req_dat_i;
    logic                    rsp_valid_o;
    logic                    rsp_ready_i;
    logic [7:0]              rsp_dat_o;
    logic [1:0]              rsp_err_o;
    logic                    sb_stb_o;
    logic                    sb_wr_o;
    logic [7:0]              sb_adr_o;
    logic [7:0]              sb_dat_o;
    logic [NUM_CH-1:0]       sb_ack_i;
    logic [8*NUM_CH-1:0]     sb_dat_i;
    logic [NUM_CH-1:0]       irq_i;
    logic [NUM_CH-1:0]       irq_en_i;
    logic [NUM_CH-1:0]       irq_clr_i;
    logic [NUM_CH-1:0]       irq_pend_o;
    logic                    irq_o;

    int n_vec = 0;
    int n_err = 0;

    sb_multi_master #(
        .NUM_CH      (NUM_CH),
        .CH_BASE     (CH_BASE),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .sb_clk_i    (sb_clk_i),
        .rst_n_i     (rst_n_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_wr_i    (req_wr_i),
        .req_adr_i   (req_adr_i),
        .req_dat_i   (req_dat_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .sb_stb_o    (sb_stb_o),
        .sb_wr_o     (sb_wr_o),
        .sb_adr_o    (sb_adr_o),
        .sb_dat_o    (sb_dat_o),
        .sb_ack_i    (sb_ack_i),
        .sb_dat_i    (sb_dat_i),
        .irq_i       (irq_i),
        .irq_en_i    (irq_en_i),
        .irq_clr_i   (irq_clr_i),
        .irq_pend_o  (irq_pend_o),
        .irq_o       (irq_o)
    );

    initial sb_clk_i = 1'b0;
    always #5 sb_clk_i = ~sb_clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge sb_clk_i);
        #1;
    endtask

    function automatic int exp_ch(input logic [7:0] adr);
        logic [15:0] base;
        base = CH_BASE;
        for (int i = 0; i < NUM_CH; i++) begin
            if (base[4*i +: 4] == adr[7:4]) return i;
        end
        return -1;
    endfunction

    // One request/response; ack_dly = strobe cycle index carrying the ack
    // (negative = never). noise holds every other channel's ack high.
    task automatic do_txn(input string tag, input bit wr, input logic [7:0] adr,
                          input logic [7:0] dat, input int ack_dly,
                          input logic [7:0] rdat, input int hold, input bit noise);
        int ch, e_err, e_stb, e_lat, stb_cnt, lat, wait_c, bus_bad, hold_bad;
        logic [7:0] e_dat, k_dat;
        logic [1:0] k_err;
        logic [NUM_CH-1:0] a;
        logic [8*NUM_CH-1:0] d;
        bit got;

        ch = exp_ch(adr);
        if (ch < 0) begin
            e_err = 2; e_stb = 0; e_dat = 8'h00;
        end else if (ack_dly >= 0 && ack_dly < TMO) begin
            e_err = 0; e_stb = ack_dly + 1; e_dat = wr ? 8'h00 : rdat;
        end else begin
            e_err = 1; e_stb = TMO; e_dat = 8'h00;
        end
        e_lat = (ch < 0) ? 1 : e_stb + 1;

        wait_c = 0;
        while (req_ready_o !== 1'b1 && wait_c < 20) begin
            tick();
            wait_c++;
        end
        n_vec++;
        if (req_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready_wait: req_ready_o=%b expected 1", tag, req_ready_o);
        end

        req_valid_i = 1'b1; req_wr_i = wr; req_adr_i = adr; req_dat_i = dat;
        tick();
        req_valid_i = 1'b0; req_wr_i = 1'b0; req_adr_i = 8'h00; req_dat_i = 8'h00;

        stb_cnt = 0; lat = 0; got = 0; bus_bad = 0;
        for (int c = 1; c <= TMO + 8 && !got; c++) begin
            if (rsp_valid_o === 1'b1) begin
                got = 1;
                lat = c;
            end else begin
                a = noise ? '1 : '0;
                d = {$urandom, $urandom};
                if (ch >= 0) begin
                    a[ch] = 1'b0;
                    d[8*ch +: 8] = rdat;
                end
                if (sb_stb_o === 1'b1) begin
                    if (sb_adr_o !== adr || sb_wr_o !== wr || (wr && sb_dat_o !== dat))
                        bus_bad++;
                    if (ch >= 0 && stb_cnt == ack_dly) a[ch] = 1'b1;
                    stb_cnt++;
                end else if (sb_adr_o !== 8'h00 || sb_wr_o !== 1'b0 || sb_dat_o !== 8'h00) begin
                    bus_bad++;
                end
                sb_ack_i = a;
                sb_dat_i = d;
                tick();
            end
        end
        sb_ack_i = '0;

        n_vec++;
        if (!got || lat != e_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d cycles (valid seen=%0d) expected %0d", tag, lat, got, e_lat);
        end
        n_vec++;
        if (stb_cnt != e_stb) begin
            n_err++;
            $display("FAIL %s strobe_len: got %0d expected %0d", tag, stb_cnt, e_stb);
        end
        n_vec++;
        if (rsp_err_o !== 2'(e_err)) begin
            n_err++;
            $display("FAIL %s rsp_err: got %b expected %b", tag, rsp_err_o, 2'(e_err));
        end
        n_vec++;
        if (rsp_dat_o !== e_dat) begin
            n_err++;
            $display("FAIL %s rsp_dat: got %h expected %h", tag, rsp_dat_o, e_dat);
        end
        n_vec++;
        if (bus_bad != 0) begin
            n_err++;
            $display("FAIL %s sb_bus: %0d bad cycles expected 0", tag, bus_bad);
        end

        k_dat = rsp_dat_o;
        k_err = rsp_err_o;
        hold_bad = 0;
        for (int h = 0; h < hold; h++) begin
            tick();
            if (rsp_valid_o !== 1'b1 || rsp_dat_o !== k_dat || rsp_err_o !== k_err ||
                req_ready_o !== 1'b0 || sb_stb_o !== 1'b0)
                hold_bad++;
        end
        if (hold > 0) begin
            n_vec++;
            if (hold_bad != 0) begin
                n_err++;
                $display("FAIL %s backpressure: %0d unstable cycles expected 0", tag, hold_bad);
            end
        end

        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        n_vec++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL %s handshake: rsp_valid=%b req_ready=%b expected 0/1", tag, rsp_valid_o, req_ready_o);
        end
    endtask

    task automatic test_reset;
        rst_n_i = 1'b0;
        req_valid_i = 1'b0; req_wr_i = 1'b0; req_adr_i = 8'h00; req_dat_i = 8'h00;
        rsp_ready_i = 1'b0; sb_ack_i = '0; sb_dat_i = '0;
        irq_i = '0; irq_en_i = '0; irq_clr_i = '0;
        tick(); tick(); tick();
        n_vec++;
        if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b0 || rsp_dat_o !== 8'h00 || rsp_err_o !== 2'b00) begin
            n_err++;
            $display("FAIL reset_rsp: ready=%b valid=%b dat=%h err=%b expected 0/0/00/00",
                     req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o);
        end
        n_vec++;
        if (sb_stb_o !== 1'b0 || sb_wr_o !== 1'b0 || sb_adr_o !== 8'h00 || sb_dat_o !== 8'h00) begin
            n_err++;
            $display("FAIL reset_sb: stb=%b wr=%b adr=%h dat=%h expected all 0",
                     sb_stb_o, sb_wr_o, sb_adr_o, sb_dat_o);
        end
        n_vec++;
        if (irq_pend_o !== 2'b00 || irq_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_irq: pend=%b irq=%b expected 00/0", irq_pend_o, irq_o);
        end
        rst_n_i = 1'b1;
        tick();
        n_vec++;
        if (req_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: req_ready_o=%b expected 1", req_ready_o);
        end
    endtask

    task automatic test_zero_wait_read;
        do_txn("zero_wait_read", 1'b0, 8'h35, 8'h00, 0, 8'hA5, 0, 1'b0);
    endtask

    task automatic test_write_wait;
        do_txn("write_wait", 1'b1, 8'h12, 8'h5C, 4, 8'h77, 0, 1'b0);
    endtask

    task automatic test_timeout_miss;
        do_txn("timeout", 1'b0, 8'h31, 8'h00, -1, 8'h99, 0, 1'b0);
        do_txn("ack_at_expiry", 1'b0, 8'h14, 8'h00, TMO - 1, 8'h3C, 0, 1'b0);
        do_txn("decode_miss", 1'b0, 8'h75, 8'h00, 0, 8'hEE, 0, 1'b0);
    endtask

    task automatic test_wrong_ch_backpressure;
        do_txn("wrong_ch_ack", 1'b0, 8'h3A, 8'h00, 3, 8'h5A, 10, 1'b1);
    endtask

    task automatic test_back_to_back;
        int acc, ok_rsp, gap_bad, last_hi;
        acc = 0; ok_rsp = 0; gap_bad = 0; last_hi = -10;
        sb_dat_i = 16'hA5_33;
        rsp_ready_i = 1'b1;
        for (int w = 0; w < 20 && req_ready_o !== 1'b1; w++) tick();
        req_valid_i = 1'b1; req_wr_i = 1'b0; req_adr_i = 8'h35;
        for (int c = 0; c < 36; c++) begin
            if (c == 30) req_valid_i = 1'b0;
            if (req_ready_o === 1'b1 && req_valid_i === 1'b1) acc++;
            if (rsp_valid_o === 1'b1 && rsp_dat_o === 8'hA5 && rsp_err_o === 2'b00) ok_rsp++;
            if (sb_stb_o === 1'b1) begin
                if (c - last_hi - 1 < 2) gap_bad++;
                last_hi = c;
            end
            sb_ack_i = (sb_stb_o === 1'b1) ? 2'b10 : 2'b00;
            tick();
        end
        sb_ack_i = '0;
        rsp_ready_i = 1'b0;
        req_adr_i = 8'h00;
        n_vec++;
        if (acc != 10) begin
            n_err++;
            $display("FAIL b2b_accepts: got %0d expected 10", acc);
        end
        n_vec++;
        if (ok_rsp != 10) begin
            n_err++;
            $display("FAIL b2b_responses: got %0d expected 10", ok_rsp);
        end
        n_vec++;
        if (gap_bad != 0) begin
            n_err++;
            $display("FAIL b2b_strobe_gap: %0d short gaps expected 0", gap_bad);
        end
    endtask

    task automatic test_random_txn;
        logic [3:0] nib;
        int dly;
        for (int t = 0; t < 16; t++) begin
            case ($urandom_range(0, 3))
                0:       nib = 4'h1;
                1:       nib = 4'h3;
                2:       nib = 4'($urandom);
                default: nib = 4'h3;
            endcase
            dly = ($urandom_range(0, 7) == 0) ? TMO + 5 : int'($urandom_range(0, 6));
            do_txn("random", 1'($urandom), {nib, 4'($urandom)}, 8'($urandom), dly,
                   8'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end
    endtask

    // pend(n+1) = rise seen across cycles n-2 -> n-1, or pend(n) without a clear in n
    task automatic test_irq;
        logic [1:0] sv [0:10];
        logic [1:0] sc [0:10];
        logic [1:0] v, c, en, v1, v2, e_pend;
        int bad_pend, bad_irq;
        sv = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01};
        sc = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
        irq_i = '0; irq_clr_i = '1; irq_en_i = '0;
        tick(); tick(); tick();
        irq_clr_i = '0;
        v1 = 2'b00; v2 = 2'b00; e_pend = 2'b00;
        bad_pend = 0; bad_irq = 0;
        for (int n = 0; n < 70; n++) begin
            if (n < 11) begin
                v = sv[n]; c = sc[n]; en = 2'b10;
            end else begin
                v  = ($urandom_range(0, 2) == 0) ? ~v1 : v1;
                c  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
                en = 2'($urandom);
            end
            irq_i = v; irq_clr_i = c; irq_en_i = en;
            #1;
            if (irq_pend_o !== e_pend) begin
                bad_pend++;
                $display("FAIL irq_pend cycle %0d: got %b expected %b", n, irq_pend_o, e_pend);
            end
            if (irq_o !== |(e_pend & en)) begin
                bad_irq++;
                $display("FAIL irq_o cycle %0d: got %b expected %b", n, irq_o, |(e_pend & en));
            end
            e_pend = (v1 & ~v2) | (e_pend & ~c);
            v2 = v1;
            v1 = v;
            tick();
        end
        irq_i = '0; irq_clr_i = '0;
        n_vec++;
        if (bad_pend != 0) n_err++;
        n_vec++;
        if (bad_irq != 0) n_err++;
    endtask

    task automatic test_reset_mid_strobe;
        int bad;
        irq_en_i = 2'b01;
        irq_i = 2'b01;
        tick(); tick(); tick();
        irq_i = 2'b00;
        n_vec++;
        if (irq_pend_o[0] !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_pend: got %b expected 1", irq_pend_o[0]);
        end
        for (int w = 0; w < 20 && req_ready_o !== 1'b1; w++) tick();
        req_valid_i = 1'b1; req_wr_i = 1'b0; req_adr_i = 8'h35;
        tick();
        req_valid_i = 1'b0; req_adr_i = 8'h00;
        tick(); tick();
        n_vec++;
        if (sb_stb_o !== 1'b1) begin
            n_err++;
            $display("FAIL mid_strobe: sb_stb_o=%b expected 1", sb_stb_o);
        end
        rst_n_i = 1'b0;
        tick();
        n_vec++;
        if (sb_stb_o !== 1'b0 || rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_strobe: stb=%b valid=%b ready=%b expected 0/0/0",
                     sb_stb_o, rsp_valid_o, req_ready_o);
        end
        n_vec++;
        if (irq_pend_o !== 2'b00 || irq_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pend_clear: pend=%b irq=%b expected 00/0", irq_pend_o, irq_o);
        end
        tick();
        rst_n_i = 1'b1;
        tick();
        n_vec++;
        if (req_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_ready: got %b expected 1", req_ready_o);
        end
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            if (rsp_valid_o !== 1'b0 || sb_stb_o !== 1'b0) bad++;
            tick();
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL post_reset_quiet: %0d cycles with stale activity expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        test_write_wait();
        test_timeout_miss();
        test_wrong_ch_backpressure();
        test_back_to_back();
        test_random_txn();
        test_irq();
        test_reset_mid_strobe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
